// File: rtl/ex_stage.sv
// ex_stage: execute stage ALU with registered outputs; the iterative 32-step multiplier
// (alu_op 10) is built only when EX_MUL_EN is defined, otherwise op 10 is reserved.
module ex_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [4:0]  in_pc,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic [31:0] store_data,
  input  logic [3:0]  alu_op,
  input  logic [2:0]  jump_type,
  input  logic        reg_wrenable,
  input  logic        mem_wrenable,
  input  logic        mem_to_reg,
  input  logic [4:0]  write_reg,
  output logic        stall,
  output logic        out_valid,
  output logic [4:0]  out_pc,
  output logic [31:0] out_alu_res,
  output logic [31:0] out_write_data,
  output logic [2:0]  out_jump_type,
  output logic        out_reg_wrenable,
  output logic        out_mem_wrenable,
  output logic        out_mem_to_reg,
  output logic [4:0]  out_write_reg
);
  logic [31:0] alu_res, res;
  logic        accept;
  always_comb begin
    alu_res = '0;
    case (alu_op)
      4'd0: alu_res = op_a + op_b;
      4'd1: alu_res = op_a - op_b;
      4'd2: alu_res = op_a & op_b;
      4'd3: alu_res = op_a | op_b;
      4'd4: alu_res = op_a ^ op_b;
      4'd5: alu_res = op_a << op_b[4:0];
      4'd6: alu_res = op_a >> op_b[4:0];
      4'd7: alu_res = $signed(op_a) >>> op_b[4:0];
      4'd8: alu_res = {31'd0, $signed(op_a) < $signed(op_b)};
      4'd9: alu_res = {31'd0, op_a < op_b};
      default: alu_res = '0;
    endcase
  end
`ifdef EX_MUL_EN
  typedef enum logic {IDLE, BUSY} state_t;
  state_t      state, state_n;
  logic [4:0]  cnt;
  logic [31:0] acc, mc, mp, mul_res;
  logic        busy, last, is_mul;
  assign busy    = state == BUSY;
  assign last    = busy && cnt == 5'd31;
  assign is_mul  = alu_op == 4'd10;
  assign mul_res = acc + (mp[0] ? mc : 32'd0);
  assign stall   = ~rst & ~flush & ((~busy & in_valid & is_mul) | (busy & ~last));
  assign accept  = ~flush & in_valid & (busy ? last : ~is_mul);
  assign res     = busy ? mul_res : alu_res;
  always_comb begin
    state_n = state;
    if (flush) state_n = IDLE;
    else if (!busy && in_valid && is_mul) state_n = BUSY;
    else if (last) state_n = IDLE;
  end
  // Operands reload every idle cycle, so the edge entering BUSY captures the MUL's operands.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= busy ? cnt + 5'd1 : 5'd0;
    end
    acc <= busy ? mul_res : 32'd0;
    mc  <= busy ? mc << 1 : op_a;
    mp  <= busy ? mp >> 1 : op_b;
  end
`else
  assign stall  = 1'b0;
  assign accept = ~flush & in_valid;
  assign res    = alu_res;
`endif
  always_ff @(posedge clk) begin
    if (rst || !accept) begin
      out_valid        <= 1'b0;
      out_pc           <= '0;
      out_alu_res      <= '0;
      out_write_data   <= '0;
      out_jump_type    <= '0;
      out_reg_wrenable <= 1'b0;
      out_mem_wrenable <= 1'b0;
      out_mem_to_reg   <= 1'b0;
      out_write_reg    <= '0;
    end else begin
      out_valid        <= 1'b1;
      out_pc           <= in_pc;
      out_alu_res      <= res;
      out_write_data   <= store_data;
      out_jump_type    <= jump_type;
      out_reg_wrenable <= reg_wrenable;
      out_mem_wrenable <= mem_wrenable;
      out_mem_to_reg   <= mem_to_reg;
      out_write_reg    <= write_reg;
    end
  end
endmodule

// File: tb/tb_ex_stage.sv
// tb_ex_stage: randomized and directed checks of ex_stage against an arithmetic reference model.
module tb_ex_stage;
  logic        clk, rst, flush, in_valid;
  logic [4:0]  in_pc, write_reg;
  logic [31:0] op_a, op_b, store_data;
  logic [3:0]  alu_op;
  logic [2:0]  jump_type;
  logic        reg_wrenable, mem_wrenable, mem_to_reg;
  logic        stall, out_valid;
  logic [4:0]  out_pc, out_write_reg;
  logic [31:0] out_alu_res, out_write_data;
  logic [2:0]  out_jump_type;
  logic        out_reg_wrenable, out_mem_wrenable, out_mem_to_reg;
  int checks = 0;
  int failures = 0;

  ex_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_pc(in_pc),
    .op_a(op_a), .op_b(op_b), .store_data(store_data), .alu_op(alu_op),
    .jump_type(jump_type), .reg_wrenable(reg_wrenable), .mem_wrenable(mem_wrenable),
    .mem_to_reg(mem_to_reg), .write_reg(write_reg), .stall(stall), .out_valid(out_valid),
    .out_pc(out_pc), .out_alu_res(out_alu_res), .out_write_data(out_write_data),
    .out_jump_type(out_jump_type), .out_reg_wrenable(out_reg_wrenable),
    .out_mem_wrenable(out_mem_wrenable), .out_mem_to_reg(out_mem_to_reg),
    .out_write_reg(out_write_reg)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  wire [80:0] obs = {out_valid, out_pc, out_alu_res, out_write_data, out_jump_type,
                     out_reg_wrenable, out_mem_wrenable, out_mem_to_reg, out_write_reg};

  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (op)
      4'd0: return a + b;
      4'd1: return a - b;
      4'd2: return a & b;
      4'd3: return a | b;
      4'd4: return a ^ b;
      4'd5: return a * (32'd1 << b[4:0]);
      4'd6: return a / (32'd1 << b[4:0]);
      4'd7: return 32'(sa >>> b[4:0]);
      4'd8: return (sa < sb) ? 32'd1 : 32'd0;
      4'd9: return ({32'd0, a} < {32'd0, b}) ? 32'd1 : 32'd0;
`ifdef EX_MUL_EN
      4'd10: return 32'(64'(a) * 64'(b));
`endif
      default: return 32'd0;
    endcase
  endfunction

  function automatic logic [80:0] golden(input logic [31:0] r);
    return {1'b1, in_pc, r, store_data, jump_type, reg_wrenable, mem_wrenable, mem_to_reg, write_reg};
  endfunction

  task automatic rand_fields();
    in_pc = 5'($urandom);
    store_data = $urandom;
    jump_type = 3'($urandom);
    reg_wrenable = 1'($urandom);
    mem_wrenable = 1'($urandom);
    mem_to_reg = 1'($urandom);
    write_reg = 5'($urandom);
  endtask

  task automatic test_reset();
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; alu_op = '0; op_a = '0; op_b = '0;
    rand_fields();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== 81'd0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL reset: outputs=%h stall=%b, required 0 and 0", obs, stall);
    end
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [3:0]  ops[4] = '{4'd0, 4'd7, 4'd8, 4'd9};
    logic [31:0] as[4]  = '{32'h7FFFFFFF, 32'h80000000, 32'hFFFFFFFF, 32'hFFFFFFFF};
    logic [31:0] bs[4]  = '{32'd1, 32'd4, 32'd1, 32'd1};
    logic [31:0] want[4] = '{32'h80000000, 32'hF8000000, 32'd1, 32'd0};
    for (int i = 0; i < 4; i++) begin
      rand_fields();
      in_valid = 1'b1; flush = 1'b0; alu_op = ops[i]; op_a = as[i]; op_b = bs[i];
      reg_wrenable = 1'b1; write_reg = 5'd3;
      @(posedge clk); #1;
      checks++;
      if (out_alu_res !== want[i] || out_write_reg !== 5'd3 || out_valid !== 1'b1 || out_reg_wrenable !== 1'b1) begin
        failures++;
        $display("FAIL directed op%0d: res=%h wr=%0d valid=%b, required res=%h wr=3 valid=1", ops[i], out_alu_res, out_write_reg, out_valid, want[i]);
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic test_random_alu();
    logic [80:0] exp;
    for (int i = 0; i < 300; i++) begin
      rand_fields();
      op_a = $urandom; op_b = $urandom;
      alu_op = 4'($urandom);
`ifdef EX_MUL_EN
      if (alu_op == 4'd10) alu_op = 4'd1;
`endif
      in_valid = ($urandom_range(3) != 0);
      flush = ($urandom_range(7) == 0);
      exp = (in_valid && !flush) ? golden(ref_alu(alu_op, op_a, op_b)) : 81'd0;
      #1;
      checks++;
      if (stall !== 1'b0) begin
        failures++;
        $display("FAIL random stall: stall=%b, required 0", stall);
      end
      @(posedge clk); #1;
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL random op%0d: outputs=%h, required %h", alu_op, obs, exp);
      end
    end
    in_valid = 1'b0; flush = 1'b0;
  endtask

  task automatic test_flush_input();
    rand_fields();
    in_valid = 1'b1; mem_wrenable = 1'b1; flush = 1'b1; alu_op = 4'd0; op_a = 32'd9; op_b = 32'd1;
    @(posedge clk); #1;
    checks++;
    if (out_mem_wrenable !== 1'b0 || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL flush_input: mem_wr=%b valid=%b, required 0 and 0", out_mem_wrenable, out_valid);
    end
    flush = 1'b0; in_valid = 1'b0;
  endtask

`ifdef EX_MUL_EN
  task automatic run_mul(input logic [31:0] a, b);
    int n;
    logic [80:0] exp;
    rand_fields();
    in_valid = 1'b1; flush = 1'b0; alu_op = 4'd10; op_a = a; op_b = b;
    exp = golden(ref_alu(4'd10, a, b));
    n = 0;
    for (int i = 0; i < 40; i++) begin
      #1;
      if (!stall) break;
      n++;
      @(posedge clk); #1;
      checks++;
      if (obs !== 81'd0) begin
        failures++;
        $display("FAIL mul bubble cycle %0d: outputs=%h, required 0", n, obs);
      end
    end
    checks++;
    if (n != 32) begin
      failures++;
      $display("FAIL mul stall length: %0d cycles, required 32", n);
    end
    @(posedge clk); #1;
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL mul result %h*%h: outputs=%h, required %h", a, b, obs, exp);
    end
  endtask

  task automatic test_mul();
    in_valid = 1'b0;
    @(posedge clk); #1;
    run_mul(32'h00010003, 32'h00000005);
    in_valid = 1'b0;
    @(posedge clk); #1;
    run_mul($urandom, $urandom);
    in_valid = 1'b0;
  endtask

  task automatic test_back_to_back();
    run_mul($urandom, $urandom);
    run_mul($urandom, $urandom);
    run_mul(32'hFFFFFFFF, 32'hFFFFFFFF);
    in_valid = 1'b0;
  endtask

  task automatic test_mul_flush();
    rand_fields();
    in_valid = 1'b1; flush = 1'b0; alu_op = 4'd10; op_a = 32'h1234; op_b = 32'h77;
    repeat (10) begin
      @(posedge clk); #1;
    end
    flush = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL mul_flush stall: stall=%b, required 0", stall);
    end
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      #1;
      checks++;
      if (obs !== 81'd0 || stall !== 1'b0) begin
        failures++;
        $display("FAIL mul_flush cycle %0d: outputs=%h stall=%b, required 0 and 0", i, obs, stall);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b1; alu_op = 4'd0; op_a = 32'd5; op_b = 32'd6;
    @(posedge clk); #1;
    checks++;
    if (out_alu_res !== 32'd11 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mul_flush followup: res=%h valid=%b, required 0000000b and 1", out_alu_res, out_valid);
    end
    in_valid = 1'b0;
  endtask
`else
  task automatic test_mul_disabled();
    rand_fields();
    in_valid = 1'b1; flush = 1'b0; alu_op = 4'd10; op_a = 32'h00010003; op_b = 32'd5;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL mul_disabled stall: stall=%b, required 0", stall);
    end
    @(posedge clk); #1;
    checks++;
    if (out_alu_res !== 32'd0 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL mul_disabled: res=%h valid=%b, required 0 and 1", out_alu_res, out_valid);
    end
    in_valid = 1'b0;
  endtask
`endif

  task automatic test_rst_busy();
    rand_fields();
    in_valid = 1'b1; flush = 1'b0; alu_op = 4'd10; op_a = 32'h55; op_b = 32'h3;
    repeat (5) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs !== 81'd0 || stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy: outputs=%h stall=%b, required 0 and 0", obs, stall);
    end
    rst = 1'b0;
    alu_op = 4'd0; op_a = 32'd2; op_b = 32'd2;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      failures++;
      $display("FAIL rst_busy idle: stall=%b, required 0", stall);
    end
    @(posedge clk); #1;
    checks++;
    if (out_alu_res !== 32'd4 || out_valid !== 1'b1) begin
      failures++;
      $display("FAIL rst_busy add: res=%h valid=%b, required 4 and 1", out_alu_res, out_valid);
    end
    in_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random_alu();
    test_flush_input();
`ifdef EX_MUL_EN
    test_mul();
    test_back_to_back();
    test_mul_flush();
`else
    test_mul_disabled();
`endif
    test_rst_busy();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
